// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned BAUD_DIV_DEFAULT = 5208;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first deserialiser, sticky rdy.
// Optional stop-bit checking with frm_err output when UART_FRM_ERR_EN is defined.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data
`ifdef UART_FRM_ERR_EN
  ,
  output logic       frm_err
`endif
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  rx_state_t state, state_nx;

  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    settle;
  logic          fall;
  logic [CW-1:0] baud_cnt;
  logic          expired;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  logic load_half;
  logic load_full;
  logic shift_en;
  logic clr_bits;
  logic complete;
  logic stop_bad;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  // History is forced low until the synchroniser holds real line data, so a
  // line that is already low when reset releases never counts as a start edge.
  assign fall    = rx_prev && !rx_s;
  assign expired = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (expired) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (expired && bit_cnt == LAST_BIT) state_nx = STOP;
      STOP:  if (expired) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    clr_bits  = 1'b0;
    complete  = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:  load_half = fall;
      START: begin
        if (expired && !rx_s) begin
          load_full = 1'b1;
          clr_bits  = 1'b1;
        end
      end
      DATA: begin
        if (expired) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
        end
      end
      STOP: begin
        if (expired) begin
`ifdef UART_FRM_ERR_EN
          complete = rx_s;
          stop_bad = !rx_s;
`else
          complete = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle   <= '0;
      rx_prev  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
    end else begin
      settle  <= {settle[0], 1'b1};
      rx_prev <= settle[1] ? rx_s : 1'b0;

      if (load_half)                     baud_cnt <= HALF_LOAD;
      else if (load_full)                baud_cnt <= FULL_LOAD;
      else if (state != IDLE && !expired) baud_cnt <= baud_cnt - CW'(1);

      if (clr_bits)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;

      if (shift_en) shreg <= {rx_s, shreg[7:1]};

      if (complete) rx_data <= shreg;

      if (complete)     rdy <= 1'b1;
      else if (clr_rdy) rdy <= 1'b0;
    end
  end

`ifdef UART_FRM_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) frm_err <= 1'b0;
    else        frm_err <= stop_bad;
  end
`else
  logic unused_stop_bad;
  assign unused_stop_bad = stop_bad;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame at BAUD_DIV=16.
module tb_uart_rx_frame;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic       rdy;
  logic [7:0] rx_data;
`ifdef UART_FRM_ERR_EN
  logic       frm_err;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_frame #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rdy     (rdy),
    .rx_data (rx_data)
`ifdef UART_FRM_ERR_EN
    ,
    .frm_err (frm_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
  endtask

  // Drives one full frame; rise = clock edges from the falling edge of RX to
  // the first 0->1 transition of rdy (-1 if none), errp = cycles with frm_err=1.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at,
                            output int rise, output int errp);
    logic [9:0] bits;
    logic       prev;
    bits = {stop, d, 1'b0};
    rise = -1;
    errp = 0;
    prev = rdy;
    for (int n = 0; n < 10 * BD; n++) begin
      RX      = bits[n / BD];
      clr_rdy = (n == clr_at);
      tick();
      if (rise < 0 && rdy && !prev) rise = n + 1;
      prev = rdy;
`ifdef UART_FRM_ERR_EN
      if (frm_err) errp++;
`endif
    end
    clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RX    = 1'b1;
    repeat (3) tick();
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
`ifdef UART_FRM_ERR_EN
    checks++;
    if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err got=%b exp=0", frm_err); end
`endif
    rst_n = 1'b1;
    idle(20);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL idle_rdy got=%b exp=0", rdy); end
  endtask

  task automatic test_single();
    int rise, errp;
    send_frame(8'h47, 1'b1, -1, rise, errp);
    checks++;
    if (rise < 153 || rise > 155) begin errors++; $display("FAIL latency got=%0d exp=153..155", rise); end
    checks++;
    if (rx_data !== 8'h47) begin errors++; $display("FAIL single_data got=%h exp=47", rx_data); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL single_rdy got=%b exp=1", rdy); end
  endtask

  task automatic test_clr();
    int rise, errp;
    idle(4);
    pulse_clr();
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy got=%b exp=0", rdy); end
    checks++;
    if (rx_data !== 8'h47) begin errors++; $display("FAIL clr_data_held got=%h exp=47", rx_data); end
    send_frame(8'h53, 1'b1, 154, rise, errp);
    checks++;
    if (rise != 155) begin errors++; $display("FAIL clr_collide_rise got=%0d exp=155", rise); end
    idle(5);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL clr_collide_rdy got=%b exp=1", rdy); end
    checks++;
    if (rx_data !== 8'h53) begin errors++; $display("FAIL clr_collide_data got=%h exp=53", rx_data); end
  endtask

  task automatic test_glitch();
    pulse_clr();
    RX = 1'b0;
    repeat (5) tick();
    idle(40);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got=%b exp=0", rdy); end
    checks++;
    if (rx_data !== 8'h53) begin errors++; $display("FAIL glitch_data got=%h exp=53", rx_data); end
  endtask

  task automatic test_back_to_back();
    int rise, errp;
    send_frame(8'h47, 1'b1, -1, rise, errp);
    checks++;
    if (rx_data !== 8'h47) begin errors++; $display("FAIL b2b_first_data got=%h exp=47", rx_data); end
    send_frame(8'h53, 1'b1, -1, rise, errp);
    checks++;
    if (rise != -1) begin errors++; $display("FAIL b2b_rdy_dropped rise_at=%0d exp=none", rise); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy got=%b exp=1", rdy); end
    checks++;
    if (rx_data !== 8'h53) begin errors++; $display("FAIL b2b_second_data got=%h exp=53", rx_data); end
  endtask

  task automatic test_reset_mid();
    int rise, errp;
    logic [9:0] bits;
    bits = {1'b1, 8'h47, 1'b0};
    for (int n = 0; n < 88; n++) begin
      RX = bits[n / BD];
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    RX    = 1'b1;
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got=%b exp=0", rdy); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h exp=00", rx_data); end
    idle(200);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_idle_rdy got=%b exp=0", rdy); end
    send_frame(8'h53, 1'b1, -1, rise, errp);
    checks++;
    if (rise < 153 || rise > 155) begin errors++; $display("FAIL midrst_latency got=%0d exp=153..155", rise); end
    checks++;
    if (rx_data !== 8'h53) begin errors++; $display("FAIL midrst_next_data got=%h exp=53", rx_data); end
  endtask

`ifdef UART_FRM_ERR_EN
  task automatic test_frm_err();
    int rise, errp;
    pulse_clr();
    send_frame(8'hA5, 1'b0, -1, rise, errp);
    idle(20);
    checks++;
    if (errp != 1) begin errors++; $display("FAIL frm_err_pulses got=%0d exp=1", errp); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL frm_err_rdy got=%b exp=0", rdy); end
    checks++;
    if (rx_data !== 8'h53) begin errors++; $display("FAIL frm_err_data got=%h exp=53", rx_data); end
    send_frame(8'hA5, 1'b1, -1, rise, errp);
    checks++;
    if (errp != 0) begin errors++; $display("FAIL frm_ok_pulses got=%0d exp=0", errp); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL frm_ok_rdy got=%b exp=1", rdy); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL frm_ok_data got=%h exp=a5", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_clr();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_FRM_ERR_EN
    test_frm_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
